// File: rtl/clock_monitor.sv
// clock_monitor: counts rising edges of an asynchronous clock over a
// window of ref_clk cycles and reports slow / fast / locked.
module clock_monitor #(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic        ref_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        mon_clk,
   input  logic [15:0] ref_counter,
   input  logic [15:0] counter,
   input  logic [7:0]  tolerance,
   output logic [15:0] measured,
   output logic        valid,
   output logic [2:0]  status
);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      REPORT
   } state_t;

   localparam logic [3:0] LOCK_MAX = 4'(LOCK_WINDOWS);

   state_t state;
   state_t state_next;

   logic [SYNC_STAGES-1:0] sync;
   logic history;
   logic mon_edge;

   logic [15:0] win_cnt;
   logic [15:0] edge_cnt;
   logic [15:0] lat_ref;
   logic [15:0] lat_cnt;
   logic [7:0]  lat_tol;
   logic [3:0]  pass_cnt;
   logic [3:0]  pass_inc;

   logic start;
   logic last;
   logic abort;

   logic signed [16:0] diff;
   logic signed [16:0] tol_s;
   logic slow;
   logic fast;

   // mon_clk synchronizer plus one history flop for rising-edge detect
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         sync    <= '0;
         history <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], mon_clk};
         history <= sync[SYNC_STAGES-1];
      end
   end

   assign mon_edge = sync[SYNC_STAGES-1] & ~history;

   // window verdict against the latched expectation
   assign diff  = $signed({1'b0, edge_cnt}) - $signed({1'b0, lat_cnt});
   assign tol_s = $signed({9'd0, lat_tol});
   assign slow  = diff < -tol_s;
   assign fast  = diff > tol_s;

   assign pass_inc = (pass_cnt >= LOCK_MAX) ? LOCK_MAX : pass_cnt + 4'd1;

   // FSM state register
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and control strobes
   always_comb begin
      state_next = state;
      valid      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      last       = (win_cnt == lat_ref - 16'd1);
      unique case (state)
         IDLE: begin
            start = enable && (ref_counter != 16'd0);
            if (start) begin
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (!enable) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (last) begin
               state_next = REPORT;
            end
         end
         REPORT: begin
            valid      = 1'b1;
            start      = enable && (ref_counter != 16'd0);
            state_next = start ? MEASURE : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // window counting, latching and status reporting
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
         lat_ref  <= '0;
         lat_cnt  <= '0;
         lat_tol  <= '0;
         pass_cnt <= '0;
         measured <= '0;
         status   <= '0;
      end else begin
         if (start) begin
            lat_ref  <= ref_counter;
            lat_cnt  <= counter;
            lat_tol  <= tolerance;
            win_cnt  <= '0;
            edge_cnt <= '0;
         end else if (state == MEASURE) begin
            win_cnt <= win_cnt + 16'd1;
            if (mon_edge) begin
               edge_cnt <= edge_cnt + 16'd1;
            end
         end

         if (abort) begin
            status   <= 3'b000;
            pass_cnt <= '0;
         end else if (valid) begin
            measured <= edge_cnt;
            if (slow) begin
               status   <= 3'b001;
               pass_cnt <= '0;
            end else if (fast) begin
               status   <= 3'b010;
               pass_cnt <= '0;
            end else begin
               pass_cnt <= pass_inc;
               status   <= {pass_inc == LOCK_MAX, 2'b00};
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: random-phase monitored clocks checked against a
// window-level reference model of the monitor.
module tb_clock_monitor;

   localparam int S    = 2;
   localparam int LOCK = 4;
   localparam int LIM  = 3000;

   logic        ref_clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        mon_clk = 1'b0;
   logic [15:0] ref_counter;
   logic [15:0] counter;
   logic [7:0]  tolerance;
   logic [15:0] measured;
   logic        valid;
   logic [2:0]  status;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int mon_per = 0;
   int mon_ph = 0;

   int b_ref[4]  = '{294, 291, 309, 306};
   int b_meas[4] = '{98, 97, 103, 102};
   int b_stat[4] = '{0, 1, 2, 0};

   clock_monitor #(
      .SYNC_STAGES(S),
      .LOCK_WINDOWS(LOCK)
   ) dut (
      .ref_clk(ref_clk),
      .reset(reset),
      .enable(enable),
      .mon_clk(mon_clk),
      .ref_counter(ref_counter),
      .counter(counter),
      .tolerance(tolerance),
      .measured(measured),
      .valid(valid),
      .status(status)
   );

   always #5 ref_clk = ~ref_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // monitored clock: high for per/2 ref cycles out of per
   always @(negedge ref_clk) begin
      if (mon_per == 0) begin
         mon_clk = 1'b0;
      end else begin
         mon_ph  = (mon_ph + 1) % mon_per;
         mon_clk = (mon_ph < mon_per / 2);
      end
   end

   task automatic set_per(input int p);
      mon_per = p;
      mon_ph  = int'($urandom_range(p - 1, 0));
   endtask

   // reference model: window schedule and edge bookkeeping
   int m_mode = 0;
   int m_left = 0;
   int m_cnt  = 0;
   int m_exp  = 0;
   int m_tol  = 0;
   int m_pass = 0;
   int m_meas = 0;
   int m_stat = 0;
   bit m_prev = 1'b0;
   bit pend[16];

   always @(posedge ref_clk) begin
      bit ev;
      int d;
      cyc++;
      if (reset) begin
         m_mode = 0;
         m_meas = 0;
         m_stat = 0;
         m_pass = 0;
         m_prev = 1'b0;
         foreach (pend[i]) pend[i] = 1'b0;
      end else begin
         ev = pend[cyc % 16];
         pend[cyc % 16] = 1'b0;
         if (mon_clk && !m_prev) pend[(cyc + S) % 16] = 1'b1;
         m_prev = mon_clk;
         if (m_mode == 1) begin
            if (!enable) begin
               m_mode = 0;
               m_stat = 0;
               m_pass = 0;
            end else begin
               if (ev) m_cnt++;
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         end else begin
            if (m_mode == 2) begin
               m_meas = m_cnt;
               d = m_cnt - m_exp;
               if (d < -m_tol) begin
                  m_stat = 1;
                  m_pass = 0;
               end else if (d > m_tol) begin
                  m_stat = 2;
                  m_pass = 0;
               end else begin
                  m_pass = (m_pass < LOCK) ? m_pass + 1 : LOCK;
                  m_stat = (m_pass == LOCK) ? 4 : 0;
               end
            end
            if (enable && ref_counter != 16'd0) begin
               m_mode = 1;
               m_left = int'(ref_counter);
               m_exp  = int'(counter);
               m_tol  = int'(tolerance);
               m_cnt  = 0;
            end else begin
               m_mode = 0;
            end
         end
      end
   end

   // every cycle: outputs against the model
   always @(negedge ref_clk) begin
      check("valid", 32'(valid), 32'(m_mode == 2));
      check("measured", 32'(measured), 32'(m_meas));
      check("status", 32'(status), 32'(m_stat));
   end

   // waits for a valid pulse, returns one cycle later with outputs updated
   task automatic wait_report(input string tag, output int at);
      int n;
      n = 0;
      while (valid !== 1'b1 && n < LIM) begin
         @(negedge ref_clk);
         n++;
      end
      at = cyc;
      check({tag, "_timeout"}, 32'(n < LIM), 32'd1);
      @(negedge ref_clk);
   endtask

   task automatic cycles_to_valid(output int n);
      n = 0;
      do begin
         @(negedge ref_clk);
         n++;
      end while (valid !== 1'b1 && n < LIM);
   endtask

   task automatic restart(input int r, input int c, input int t);
      enable      = 1'b0;
      ref_counter = 16'(r);
      counter     = 16'(c);
      tolerance   = 8'(t);
      repeat (6) @(negedge ref_clk);
      enable = 1'b1;
   endtask

   initial begin
      int t0;
      int t1;
      int n;
      int nv;
      int p;
      int r;
      int lo;
      logic [15:0] keep;
      t0 = 0;

      reset       = 1'b1;
      enable      = 1'b0;
      ref_counter = 16'd400;
      counter     = 16'd100;
      tolerance   = 8'd2;
      set_per(4);
      repeat (3) @(negedge ref_clk);
      check("rst_measured", 32'(measured), 32'd0);
      check("rst_status", 32'(status), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);

      reset  = 1'b0;
      enable = 1'b1;
      for (int w = 1; w <= 5; w++) begin
         wait_report("nom", t1);
         check("nom_range", 32'(measured >= 99 && measured <= 101), 32'd1);
         check("nom_status", 32'(status), (w >= 4) ? 32'd4 : 32'd0);
         if (w > 1) check("nom_period", 32'(t1 - t0), 32'd401);
         t0 = t1;
      end

      set_per(3);
      wait_report("fast1", t1);
      check("fast_unlock", 32'(status), 32'd2);
      wait_report("fast2", t1);
      check("fast_range", 32'(measured >= 133 && measured <= 134), 32'd1);
      check("fast_status", 32'(status), 32'd2);

      set_per(5);
      repeat (50) @(negedge ref_clk);
      restart(400, 100, 2);
      check("abort_clear", 32'(status), 32'd0);
      for (int w = 1; w <= 2; w++) begin
         wait_report("slow", t1);
         check("slow_meas", 32'(measured), 32'd80);
         check("slow_status", 32'(status), 32'd1);
      end

      set_per(4);
      repeat (20) @(negedge ref_clk);
      restart(400, 100, 2);
      for (int w = 1; w <= 4; w++) begin
         wait_report("relock", t1);
         check("relock_meas", 32'(measured), 32'd100);
         check("relock_status", 32'(status), (w == 4) ? 32'd4 : 32'd0);
      end

      set_per(3);
      for (int i = 0; i < 4; i++) begin
         restart(b_ref[i], 100, 2);
         wait_report("bound", t1);
         check("bound_meas", 32'(measured), 32'(b_meas[i]));
         check("bound_status", 32'(status), 32'(b_stat[i]));
      end

      set_per(4);
      restart(400, 100, 2);
      for (int w = 1; w <= 4; w++) wait_report("prelock", t1);
      check("prelock_status", 32'(status), 32'd4);
      keep = measured;
      repeat (200) @(negedge ref_clk);
      enable = 1'b0;
      nv = 0;
      repeat (500) begin
         @(negedge ref_clk);
         if (valid === 1'b1) nv++;
      end
      check("abort_novalid", 32'(nv), 32'd0);
      check("abort_status", 32'(status), 32'd0);
      check("abort_meas", 32'(measured), 32'(keep));
      enable = 1'b1;
      cycles_to_valid(n);
      check("reenable_lat", 32'(n), 32'd401);

      @(negedge ref_clk);
      repeat (100) @(negedge ref_clk);
      reset = 1'b1;
      @(negedge ref_clk);
      check("midrst_meas", 32'(measured), 32'd0);
      check("midrst_status", 32'(status), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      reset       = 1'b0;
      ref_counter = 16'd0;
      nv = 0;
      repeat (60) begin
         @(negedge ref_clk);
         if (valid === 1'b1) nv++;
      end
      check("zero_novalid", 32'(nv), 32'd0);
      ref_counter = 16'd10;
      cycles_to_valid(n);
      check("short_lat", 32'(n), 32'd11);
      @(negedge ref_clk);
      check("short_meas", 32'(measured >= 2 && measured <= 3), 32'd1);
      check("short_status", 32'(status), 32'd1);

      for (int k = 0; k < 6; k++) begin
         p = int'($urandom_range(9, 3));
         r = int'($urandom_range(300, 20));
         lo = r / p;
         set_per(p);
         restart(r, lo + int'($urandom_range(4, 0)) - 2,
                 int'($urandom_range(3, 0)));
         for (int w = 0; w < 3; w++) begin
            wait_report("rand", t1);
            check("rand_range",
                  32'(int'(measured) >= lo && int'(measured) <= lo + 1),
                  32'd1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
